// File: rtl/kgp_shift_pkg.sv
// kgp_shift_pkg: shared state encoding and direction/type constants for the iterative shifter.
package kgp_shift_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic TYPE_LOG  = 1'b0;
    localparam logic TYPE_ARI  = 1'b1;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational shift of WIDTH bits by 0..STEP positions, left/logical-right/arithmetic-right.
module shift_step
    import kgp_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [KW-1:0]    k,
    input  logic             dir,
    input  logic             typ,
    output logic [WIDTH-1:0] res
);
    logic signed [WIDTH-1:0] sdata;
    logic [WIDTH-1:0] asr;
    // kept as a separate signed net so the ternary below cannot demote >>> to a logical shift
    assign sdata = data;
    assign asr   = sdata >>> k;
    assign res   = (dir == DIR_RIGHT) ? ((typ == TYPE_ARI) ? asr : data >> k) : data << k;
endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shifter consuming up to STEP bits per clock behind a start/done handshake.
// The shift-type input is named typ because type is a reserved word.
module seq_shifter
    import kgp_shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   shamt,
    input  logic             dir,
    input  logic             typ,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);
    localparam int KW = $clog2(STEP + 1);

    state_t state, next_state;
    logic [SHW-1:0] rem;
    logic [WIDTH-1:0] data, shifted;
    logic dir_q, typ_q, accept, last;
    logic [31:0] rem_w;
    logic [KW-1:0] k;

    assign rem_w  = 32'(rem);
    assign k      = KW'((rem_w < STEP) ? rem_w : STEP);
    assign last   = rem_w <= STEP;
    assign accept = start && (state != SHIFT);

    shift_step #(.WIDTH(WIDTH), .STEP(STEP), .KW(KW)) u_step (
        .data(data),
        .k   (k),
        .dir (dir_q),
        .typ (typ_q),
        .res (shifted)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = (state == SHIFT) ? (last ? DONE : SHIFT) : (start ? SHIFT : IDLE);
    end

    always_comb begin
        busy = state == SHIFT;
        done = state == DONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data  <= '0;
            rem   <= '0;
            dir_q <= DIR_LEFT;
            typ_q <= TYPE_LOG;
        end else if (accept) begin
            data  <= a;
            rem   <= shamt;
            dir_q <= dir;
            typ_q <= typ;
        end else if (state == SHIFT) begin
            data <= shifted;
            rem  <= rem - SHW'(k);
        end
    end

    assign out = data;
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: directed table-driven checks of seq_shifter at STEP=1 plus a STEP=4 instance.
module tb_seq_shifter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, start4 = 1'b0;
    logic [31:0] a = '0;
    logic [4:0]  shamt = '0;
    logic        dir = 1'b0, typ = 1'b0;
    logic        busy, done, busy4, done4;
    logic [31:0] out, out4;
    logic        sel4 = 1'b0;
    logic        cdone, cbusy;
    logic [31:0] cout;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  shamt;
        logic        dir;
        logic        typ;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    seq_shifter #(.WIDTH(32), .STEP(1)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .shamt(shamt),
        .dir(dir), .typ(typ), .busy(busy), .done(done), .out(out)
    );

    seq_shifter #(.WIDTH(32), .STEP(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a), .shamt(shamt),
        .dir(dir), .typ(typ), .busy(busy4), .done(done4), .out(out4)
    );

    assign cdone = sel4 ? done4 : done;
    assign cbusy = sel4 ? busy4 : busy;
    assign cout  = sel4 ? out4 : out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wait_done(inout int lat, inout int bcnt);
        while (!cdone && lat < 100) begin
            if (cbusy) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic op(input vec_t v, input string name);
        int lat = 0;
        int bcnt = 0;
        @(negedge clk);
        a = v.a; shamt = v.shamt; dir = v.dir; typ = v.typ;
        if (sel4) start4 = 1'b1; else start = 1'b1;
        @(negedge clk);
        start = 1'b0; start4 = 1'b0;
        wait_done(lat, bcnt);
        chk({name, "_lat"}, lat, v.lat);
        chk({name, "_out"}, cout, v.exp);
        chk({name, "_busy"}, bcnt, v.lat);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, bcnt, seen;
        vecs[0] = '{32'h8000_0000, 5'd3,  1'b0, 1'b0, 32'h0000_0000, 3};
        vecs[1] = '{32'h8000_0000, 5'd3,  1'b1, 1'b0, 32'h1000_0000, 3};
        vecs[2] = '{32'h8000_0000, 5'd1,  1'b1, 1'b1, 32'hC000_0000, 1};
        vecs[3] = '{32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, 31};
        vecs[4] = '{32'hDEAD_BEEF, 5'd0,  1'b0, 1'b0, 32'hDEAD_BEEF, 1};
        vecs[5] = '{32'h0000_00F0, 5'd4,  1'b1, 1'b1, 32'h0000_000F, 4};
        vecs[6] = '{32'h7000_0000, 5'd2,  1'b1, 1'b1, 32'h1C00_0000, 2};
        vecs[7] = '{32'h1234_5678, 5'd8,  1'b0, 1'b1, 32'h3456_7800, 8};
        vecs[8] = '{32'hF000_000F, 5'd4,  1'b1, 1'b0, 32'h0F00_0000, 4};

        repeat (2) @(negedge clk);
        chk("rst_out", out, 32'h0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) op(vecs[i], $sformatf("vec%0d", i));

        sel4 = 1'b1;
        op('{32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, 8}, "step4_asr31");
        op('{32'h0000_0001, 5'd5,  1'b0, 1'b0, 32'h0000_0020, 2}, "step4_sll5");
        sel4 = 1'b0;
        @(negedge clk);

        // back-to-back: second start issued in the DONE cycle
        a = 32'hDEAD_BEEF; shamt = 5'd0; dir = 1'b0; typ = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 0; bcnt = 0;
        wait_done(lat, bcnt);
        chk("b2b_first_lat", lat, 1);
        chk("b2b_first_out", out, 32'hDEAD_BEEF);
        a = 32'h1; shamt = 5'd4; dir = 1'b0; typ = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accept_busy", busy, 1);
        lat = 0; bcnt = 0;
        wait_done(lat, bcnt);
        chk("b2b_second_lat", lat, 4);
        chk("b2b_second_out", out, 32'h10);
        @(negedge clk);

        // start while busy is ignored
        a = 32'h8000_0000; shamt = 5'd5; dir = 1'b1; typ = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 32'hFFFF_FFFF; shamt = 5'd1; dir = 1'b0; typ = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; lat = 2; bcnt = 2;
        wait_done(lat, bcnt);
        chk("ign_lat", lat, 5);
        chk("ign_out", out, 32'h0400_0000);
        @(negedge clk);
        chk("ign_idle_busy", busy, 0);
        chk("ign_idle_done", done, 0);
        chk("ign_hold_out", out, 32'h0400_0000);

        // asynchronous reset during SHIFT cycle 2 of a 10-cycle shift
        a = 32'hFFFF_FFFF; shamt = 5'd10; dir = 1'b0; typ = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_out", out, 32'h0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        seen = 0;
        repeat (3) @(negedge clk) if (done) seen = 1;
        rst = 1'b1;
        repeat (12) @(negedge clk) if (done || busy) seen = 1;
        chk("arst_no_done", seen, 0);
        op(vecs[1], "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_shifter.md
# seq_shifter

Multi-cycle iterative shift unit for the KGP-RISC execute stage: the sequential counterpart to the single-cycle combinational shifter. It accepts an operand, a shift amount, a direction and a type through a start/done handshake. It then shifts by at most STEP bits per clock until the requested amount is consumed. It serves area-constrained builds where a full barrel shifter is not affordable, and the control FSM stalls on `busy`.

## Interface
- `WIDTH`, 32, operand width in bits.
- `STEP`, 1, bits shifted per clock; a power of two, 1 ≤ STEP ≤ WIDTH.
- `SHW`, $clog2(WIDTH), shift-amount width (derived; 5 at default).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `start`  in  1  request; sampled only when the unit can accept.
- `a`  in  WIDTH  operand; latched on accept.
- `shamt`  in  SHW  shift amount; latched on accept.
- `dir`  in  1  0 = left, 1 = right; latched on accept.
- `type`  in  1  0 = logical, 1 = arithmetic; latched on accept. Arithmetic left behaves as logical left.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle pulse; `out` is valid.
- `out`  out  WIDTH  result register; holds its value until the next accept.

## Operation
- FSM has three states: IDLE, SHIFT, DONE.
  - IDLE: on `start`, latch `a` into the data register, latch `shamt` into counter `rem`, latch `dir` and `type`. Go to SHIFT.
  - SHIFT: if `rem` = 0, go to DONE and leave the data unchanged. Otherwise shift by k = min(STEP, rem) and set rem ← rem − k. If the old rem ≤ STEP, go to DONE.
  - DONE: `done` = 1 for this cycle only. On `start`, accept exactly as in IDLE (back-to-back operation). Otherwise go to IDLE.
- Shift fill rules:
  - Left shifts fill with 0.
  - Logical right shifts fill with 0.
  - Arithmetic right shifts fill with the latched operand's MSB. The MSB is sign-preserved at every step.
- `start` while in SHIFT is ignored. Inputs `a`, `shamt`, `dir` and `type` are don't-care outside the accept edge.
- `out` is driven directly by the data register. It is not valid mid-shift; consumers qualify it with `done`.
- `rem` is SHW bits wide and never underflows, because k ≤ rem.

## Timing
- Reset values: state = IDLE, `busy` = 0, `done` = 0, `out` = 0, `rem` = 0.
- Reset asserted mid-operation aborts the operation immediately. No `done` is produced. After reset is released the unit is in IDLE.
- Accept edge e0 is the edge where `start` = 1 in IDLE or DONE. `busy` rises after e0.
- Let N = max(1, ceil(shamt/STEP)).
  - DONE is entered at edge eN.
  - `done` and the final `out` are visible in the cycle after eN.
  - `busy` falls at eN.
- Worked latencies:
  - STEP = 1, shamt = 31: `done` after e31.
  - shamt = 0: `done` after e1, with `out` = `a`.
- Throughput: a new `start` in the DONE cycle is accepted at that edge. The back-to-back period is therefore N + 1 cycles.

## Structure
- Package `kgp_shift_pkg` holds:
  - the state enum (IDLE/SHIFT/DONE);
  - constants DIR_LEFT = 0, DIR_RIGHT = 1, TYPE_LOG = 0, TYPE_ARI = 1.
- Sub-module `shift_step`: combinational shift of WIDTH bits by 0..STEP positions.
  - Inputs: data, k, dir, type.
  - One instance sits in the datapath.
- Top level: FSM, counter and data register, about 150–250 lines total.

## Test plan
- STEP = 1, a = 32'h8000_0000, shamt = 3, dir = 0, type = 0 → `done` after e3, `out` = 32'h0000_0000, `busy` high for exactly 3 cycles.
- Same `a`, shamt = 3, dir = 1, type = 0 → `out` = 32'h1000_0000. Then shamt = 1, dir = 1, type = 1 → `out` = 32'hC000_0000.
- a = 32'h8000_0000, shamt = 31, dir = 1, type = 1 → `done` after e31, `out` = 32'hFFFF_FFFF. With STEP = 4 the same input gives `done` after e8 and the same result.
- shamt = 0, a = 32'hDEAD_BEEF → `done` after e1, `out` = 32'hDEAD_BEEF. Also drive `start` on the DONE cycle with a = 1, shamt = 4, dir = 0 → accepted, next `done` 4 cycles later with `out` = 32'h10.
- `start` pulsed with different operands while `busy` is high → ignored, and the original result is unchanged.
- `rst` dropped at SHIFT cycle 2 of a 10-cycle shift → all outputs 0 immediately, no `done` pulse, and the next `start` behaves normally.
